// File: rtl/md_ctrl_pkg.sv
// Shared MIPS definitions for the multiply/divide path.
// Op codes, default latencies and MD FSM encoding.
package mips_defs;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // True for ops that occupy the multi-cycle unit.
  function automatic logic is_arith(
    input logic [2:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl_arith.sv
// Combinational multiply/divide result generator.
// Owns signedness, divide-by-zero and overflow rules.
module md_arith
  import mips_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic               bz;
  logic               ovf;

  assign sa    = {{32{a[31]}}, a};
  assign sb    = {{32{b[31]}}, b};
  assign sprod = sa * sb;
  assign uprod = {32'd0, a} * {32'd0, b};
  assign sq    = $signed(a) / $signed(b);
  assign sr    = $signed(a) % $signed(b);
  assign uq    = a / b;
  assign ur    = a % b;
  assign bz    = (b == 32'd0);
  assign ovf   = (a == 32'h8000_0000) &&
                 (b == 32'hFFFF_FFFF);

  // Select the result word pair for the requested op.
  always_comb begin
    hi = '0;
    lo = '0;
    unique case (1'b1)
      op == MD_MULT: begin
        hi = sprod[63:32];
        lo = sprod[31:0];
      end
      op == MD_MULTU: begin
        hi = uprod[63:32];
        lo = uprod[31:0];
      end
      op == MD_DIV: begin
        if (bz) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (ovf) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else begin
          hi = sr;
          lo = sq;
        end
      end
      op == MD_DIVU: begin
        if (bz) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = ur;
          lo = uq;
        end
      end
      default: begin
        hi = '0;
        lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencing controller.
// Holds HI/LO, models unit latency, raises D-stage stall.
module md_ctrl
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startE,
  input  logic [2:0]  mdOpE,
  input  logic [31:0] srcAE,
  input  logic [31:0] srcBE,
  input  logic        mdUseD,
  output logic        busy,
  output logic        stallD,
  output logic [31:0] hiOut,
  output logic [31:0] loOut
);

  md_state_e   state;
  md_state_e   state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [31:0] pendHi;
  logic [31:0] pendLo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] ar_hi;
  logic [31:0] ar_lo;
  logic        ld_pend;
  logic        commit;
  logic        wr_hi;
  logic        wr_lo;

  md_arith u_arith (
    .op (mdOpE),
    .a  (srcAE),
    .b  (srcBE),
    .hi (ar_hi),
    .lo (ar_lo)
  );

  // State and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, counter load/decrement and write strobes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ld_pend = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    unique case (state)
      IDLE: begin
        if (startE && is_arith(mdOpE)) begin
          state_n = BUSY;
          ld_pend = 1'b1;
          if (mdOpE == MD_MULT || mdOpE == MD_MULTU)
            cnt_n = 4'(MULT_CYCLES);
          else
            cnt_n = 4'(DIV_CYCLES);
        end else if (startE && mdOpE == MD_MTHI) begin
          wr_hi = 1'b1;
        end else if (startE && mdOpE == MD_MTLO) begin
          wr_lo = 1'b1;
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_n   = '0;
          state_n = IDLE;
          commit  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pending result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendHi <= '0;
      pendLo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (ld_pend) begin
        pendHi <= ar_hi;
        pendLo <= ar_lo;
      end
      if (commit) begin
        hi <= pendHi;
        lo <= pendLo;
      end
      if (wr_hi) hi <= srcAE;
      if (wr_lo) lo <= srcAE;
    end
  end

  assign busy   = (state == BUSY);
  assign stallD = mdUseD & (startE | busy);
  assign hiOut  = hi;
  assign loOut  = lo;

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl.
// Random and directed ops against a longint reference model.
module tb_md_ctrl;

  localparam int NM = 5;
  localparam int ND = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startE = 1'b0;
  logic [2:0]  mdOpE = '0;
  logic [31:0] srcAE = '0;
  logic [31:0] srcBE = '0;
  logic        mdUseD = 1'b0;
  logic        busy;
  logic        stallD;
  logic [31:0] hiOut;
  logic [31:0] loOut;

  int n_cmp = 0;
  int n_err = 0;
  int ill_cnt = 0;
  int last_gap = 0;
  int run = 0;
  int idle = 0;
  logic prev = 1'b0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;
  exp_t sb[$];

  md_ctrl #(
    .MULT_CYCLES (NM),
    .DIV_CYCLES  (ND)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .startE (startE),
    .mdOpE  (mdOpE),
    .srcAE  (srcAE),
    .srcBE  (srcBE),
    .mdUseD (mdUseD),
    .busy   (busy),
    .stallD (stallD),
    .hiOut  (hiOut),
    .loOut  (loOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the ISA rules.
  function automatic logic [63:0] ref_op(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        p = 64'(sa * sb);
        return p;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        return p;
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Starts issued while the unit is busy.
  always @(posedge clk)
    if (reset && startE && busy) ill_cnt++;

  // Monitor: pop and compare whenever a busy run ends.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      prev = 1'b0;
      run = 0;
      idle = 0;
    end else begin
      if (busy) begin
        if (!prev) begin
          last_gap = idle;
          run = 0;
        end
        run++;
      end else begin
        if (prev) begin
          idle = 0;
          if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("res_hi", hiOut, e.hi);
            check("res_lo", loOut, e.lo);
            check("busy_len", run, e.n);
          end
        end
        idle++;
      end
      prev = busy;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 60);
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Called at a negedge with the unit idle.
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    startE = 1'b1;
    mdOpE  = op;
    srcAE  = a;
    srcBE  = b;
    if (op <= 3'd3) begin
      r = ref_op(op, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.n  = (op < 3'd2) ? NM : ND;
      sb.push_back(e);
      ref_hi = e.hi;
      ref_lo = e.lo;
    end else if (op == 3'd4) begin
      ref_hi = a;
    end else if (op == 3'd5) begin
      ref_lo = a;
    end
    @(posedge clk);
    #1;
    startE = 1'b0;
    if (op > 3'd3) begin
      check("mt_hi", hiOut, ref_hi);
      check("mt_lo", loOut, ref_lo);
      check("mt_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int st;
    logic [2:0]  op;
    logic [31:0] a, b;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hiOut, 32'd0);
    check("rst_lo", loOut, 32'd0);
    check("rst_stall", 32'(stallD), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("mult_hi", hiOut, 32'hFFFF_FFFF);
    check("mult_lo", loOut, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_hi", hiOut, 32'hFFFF_FFFF);
    check("div_lo", loOut, 32'hFFFF_FFFD);

    issue(3'd3, 32'hDEAD_BEEF, 32'd0);
    wait_idle();
    check("divu0_hi", hiOut, 32'hDEAD_BEEF);
    check("divu0_lo", loOut, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("ovf_hi", hiOut, 32'd0);
    check("ovf_lo", loOut, 32'h8000_0000);

    @(negedge clk);
    issue(3'd4, 32'h1234_5678, 32'd0);
    @(negedge clk);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    @(negedge clk);

    mdUseD = 1'b1;
    #1;
    check("stall_idle", 32'(stallD), 32'd0);
    startE = 1'b1;
    mdOpE  = 3'd1;
    srcAE  = 32'hFFFF_FFFF;
    srcBE  = 32'h0000_0010;
    begin
      exp_t e;
      e.hi = 32'h0000_000F;
      e.lo = 32'hFFFF_FFF0;
      e.n  = NM;
      sb.push_back(e);
      ref_hi = e.hi;
      ref_lo = e.lo;
    end
    #1;
    st = stallD ? 1 : 0;
    @(posedge clk);
    #1;
    startE = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!stallD) break;
      st++;
    end
    check("stall_len", st, 32'd6);
    check("stall_lo", loOut, 32'hFFFF_FFF0);
    check("stall_busy", 32'(busy), 32'd0);
    mdUseD = 1'b0;

    issue(3'd0, 32'd7, 32'd9);
    @(negedge clk);
    @(negedge clk);
    startE = 1'b1;
    mdOpE  = 3'd0;
    srcAE  = 32'd100;
    srcBE  = 32'd100;
    @(posedge clk);
    #1;
    startE = 1'b0;
    wait_idle();
    check("ign_lo", loOut, 32'd63);
    check("ill_cnt", ill_cnt, 32'd1);

    issue(3'd0, 32'd1000, 32'hFFFF_FFFD);
    wait_idle();
    issue(3'd2, 32'd100, 32'hFFFF_FFF9);
    wait_idle();
    check("b2b_gap", last_gap, 32'd1);
    check("b2b_hi", hiOut, 32'd2);
    check("b2b_lo", loOut, 32'hFFFF_FFF2);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) b = b >> 20;
      issue(op, a, b);
      wait_idle();
      check("rnd_hi", hiOut, ref_hi);
      check("rnd_lo", loOut, ref_lo);
    end

    check("pre_rst_hi", 32'(hiOut != 0), 32'd1);
    issue(3'd2, 32'd12345, 32'd7);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_hi", hiOut, 32'd0);
    check("mid_lo", loOut, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    repeat (15) @(negedge clk);
    check("post_busy", 32'(busy), 32'd0);
    check("post_hi", hiOut, 32'd0);
    check("post_lo", loOut, 32'd0);
    check("post_sb", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
